// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: control sequencer for an iterative shift-and-add multiplier.
// Issues one-cycle load/add/shift enables to external register banks for
// WIDTH iterations; the datapath itself lives outside this block.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       begin a multiply (sampled only in IDLE)
//   abort       synchronous abort back to IDLE (ignored in IDLE)
//   mplier_lsb  bit 0 of the multiplier shift register
//   load_en     load operands, clear accumulator
//   add_en      accumulator += multiplicand (EVAL and mplier_lsb)
//   shift_en    right-shift accumulator:multiplier pair
//   busy        high in every state except IDLE
//   done        one-cycle pulse when the product is valid
//   iter        iterations remaining
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CW    = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          mplier_lsb,
    output logic          load_en,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        load_en  = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy    = 1'b1;
                load_en = 1'b1;
                iter_d  = CW'(WIDTH);
                state_d = EVAL;
            end
            EVAL: begin
                busy    = 1'b1;
                add_en  = mplier_lsb;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                // Saturating decrement: iter==1 is the terminal iteration,
                // and a count of 0 can never wrap around to re-enter EVAL.
                iter_d   = (iter_q != '0) ? iter_q - CW'(1) : '0;
                state_d  = (iter_q <= CW'(1)) ? DONE : EVAL;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition decided above.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            iter_d  = '0;
        end
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: self-checking bench for mult_seq_ctrl (WIDTH=10).
// Expected enables/status come from a cycle schedule derived from the
// operation timeline; products are checked against plain a*b using a
// register-level datapath model driven by the DUT's enables.
module tb_mult_seq_ctrl;

    localparam int unsigned W  = 10;
    localparam int unsigned CW = 5;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          mplier_lsb;
    logic          load_en;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    int vectors;
    int miscompares;

    mult_seq_ctrl #(.WIDTH(W), .CW(CW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .mplier_lsb (mplier_lsb),
        .load_en    (load_en),
        .add_en     (add_en),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done),
        .iter       (iter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view of all outputs: {load, add, shift, busy, done, iter}.
    function automatic logic [CW+4:0] outs();
        return {load_en, add_en, shift_en, busy, done, iter};
    endfunction

    task automatic test_reset();
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        mplier_lsb = 1'b0;
        #2;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", outs(), {(CW+5){1'b0}});
        end
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #2;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %b expected %b", outs(), {(CW+5){1'b0}});
        end
    endtask

    // Runs one multiply from an IDLE cycle (+2 after an edge) and ends in the
    // IDLE cycle that follows DONE. With noise set, start toggles randomly
    // while the operation is in flight and must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input string name);
        logic [W:0]    acc;
        logic [W-1:0]  mc, mp;
        logic          pl, pa, ps;
        int            n_add, n_shift;
        logic [CW+4:0] exp_o;
        logic          e_load, e_add, e_shift, e_busy, e_done, e_eval;
        int            e_iter;
        logic [2*W-1:0] prod;
        acc = '0; mc = '0; mp = '0;
        pl = 1'b0; pa = 1'b0; ps = 1'b0;
        n_add = 0; n_shift = 0;
        start = 1'b1;
        @(posedge clock);
        for (int cyc = 1; cyc <= 2 * int'(W) + 3; cyc++) begin
            #1;
            if (pl) begin mc = a; mp = b; acc = '0; end
            if (pa) acc = acc + {1'b0, mc};
            if (ps) {acc, mp} = {acc, mp} >> 1;

            e_eval  = (cyc >= 2) && (cyc <= 2 * int'(W) + 1) && (cyc % 2 == 0);
            e_load  = (cyc == 1);
            e_shift = (cyc >= 3) && (cyc <= 2 * int'(W) + 1) && (cyc % 2 == 1);
            e_add   = e_eval && b[(cyc - 2) / 2];
            e_done  = (cyc == 2 * int'(W) + 2);
            e_busy  = (cyc <= 2 * int'(W) + 2);
            e_iter  = (cyc >= 2 && cyc <= 2 * int'(W) + 1) ? int'(W) - (cyc - 2) / 2 : 0;
            exp_o   = {e_load, e_add, e_shift, e_busy, e_done, CW'(e_iter)};

            start      = (noise && cyc <= 2 * int'(W) + 2) ? 1'($urandom % 2) : 1'b0;
            mplier_lsb = e_eval ? mp[0] : 1'($urandom % 2);
            #1;
            vectors++;
            if (outs() !== exp_o) begin
                miscompares++;
                $display("FAIL %s cyc=%0d: got l/a/s/b/d/iter=%b expected %b",
                         name, cyc, outs(), exp_o);
            end
            pl = load_en; pa = add_en; ps = shift_en;
            if (add_en) n_add++;
            if (shift_en) n_shift++;
            if (cyc < 2 * int'(W) + 3) @(posedge clock);
        end
        start = 1'b0;
        prod = {acc[W-1:0], mp};
        vectors++;
        if (prod !== (2*W)'(a * b)) begin
            miscompares++;
            $display("FAIL %s_product: got %h expected %h", name, prod, (2*W)'(a * b));
        end
        vectors++;
        if (n_add !== $countones(b) || n_shift !== int'(W)) begin
            miscompares++;
            $display("FAIL %s_pulses: got add=%0d shift=%0d expected add=%0d shift=%0d",
                     name, n_add, n_shift, $countones(b), W);
        end
    endtask

    task automatic test_basic();
        run_op(10'h3FF, 10'h3FF, 1'b0, "basic");
    endtask

    task automatic test_zero();
        run_op(10'($urandom), 10'h000, 1'b0, "zero_mplier");
    endtask

    task automatic test_alternating();
        run_op(10'h002, 10'h155, 1'b0, "alternating");
    endtask

    task automatic test_random_busy_start();
        for (int i = 0; i < 6; i++)
            run_op(10'($urandom), 10'($urandom), 1'b1, "random_busy_start");
    endtask

    task automatic test_start_held();
        int done_q[$];
        int load_q[$];
        int idle_q[$];
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clock);
            #1 mplier_lsb = 1'($urandom % 2);
            #1;
            if (done) done_q.push_back(cyc);
            if (load_en) load_q.push_back(cyc);
            if (!busy) idle_q.push_back(cyc);
        end
        start = 1'b0;
        vectors++;
        if (done_q.size() != 2 || done_q[0] != 22 || done_q[1] != 45) begin
            miscompares++;
            $display("FAIL held_done: got n=%0d first=%0d second=%0d expected n=2 first=22 second=45",
                     done_q.size(), done_q[0], done_q[1]);
        end
        vectors++;
        if (idle_q.size() != 2 || idle_q[0] != 23 || idle_q[1] != 46) begin
            miscompares++;
            $display("FAIL held_idle: got n=%0d first=%0d second=%0d expected n=2 first=23 second=46",
                     idle_q.size(), idle_q[0], idle_q[1]);
        end
        vectors++;
        if (load_q.size() != 3 || load_q[0] != 1 || load_q[1] != 24 || load_q[2] != 47) begin
            miscompares++;
            $display("FAIL held_load: got n=%0d loads=%0d,%0d,%0d expected n=3 loads=1,24,47",
                     load_q.size(), load_q[0], load_q[1], load_q[2]);
        end
        // Third operation is mid-flight; abort back to IDLE.
        abort = 1'b1;
        @(posedge clock);
        #2 abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || iter !== '0) begin
            miscompares++;
            $display("FAIL held_abort_idle: got busy=%b iter=%0d expected busy=0 iter=0", busy, iter);
        end
    endtask

    task automatic test_abort();
        // abort while idle does nothing
        abort = 1'b1;
        @(posedge clock);
        #2 abort = 1'b0;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL abort_in_idle: got %b expected %b", outs(), {(CW+5){1'b0}});
        end
        mplier_lsb = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clock);
            #2;
            if (cyc == 1) start = 1'b0;
        end
        // cycle 8 is the EVAL of iteration 4
        vectors++;
        if (busy !== 1'b1 || iter !== CW'(W - 3) || shift_en !== 1'b0 || load_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre_eval4: got busy=%b iter=%0d shift=%b load=%b expected busy=1 iter=%0d shift=0 load=0",
                     busy, iter, shift_en, load_en, W - 3);
        end
        abort = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #2;
        abort = 1'b0;
        start = 1'b0;
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL abort_next_edge: got %b expected %b", outs(), {(CW+5){1'b0}});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #2;
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_stays_idle: got busy=%b done=%b expected busy=0 done=0", busy, done);
            end
        end
        run_op(10'h3FF, 10'h3FF, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1;
        @(posedge clock);
        #2 start = 1'b0;
        for (int cyc = 2; cyc <= 11; cyc++) begin
            @(posedge clock);
            #1 mplier_lsb = 1'($urandom % 2);
            #1;
        end
        // cycle 11: SHIFT with six iterations remaining
        vectors++;
        if (shift_en !== 1'b1 || iter !== CW'(6) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_shift: got shift=%b iter=%0d busy=%b expected shift=1 iter=6 busy=1",
                     shift_en, iter, busy);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || shift_en !== 1'b0 || iter !== '0 || done !== 1'b0 || load_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got busy=%b shift=%b iter=%0d done=%b load=%b expected all 0",
                     busy, shift_en, iter, done, load_en);
        end
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #2;
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || load_en !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_after_release: got busy=%b done=%b load=%b expected 0 0 0",
                         busy, done, load_en);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_zero();
        test_alternating();
        test_random_busy_start();
        test_start_held();
        test_abort();
        test_reset_mid_op();
        run_op(10'($urandom), 10'($urandom), 1'b0, "post_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
